exc_commit_ctrl: RTL and testbench
==================================

EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

Interface
REQ-001 Parameter ECODE_INT, default 6'h0: ecode reported for interrupts.
REQ-002 Parameter CNT_W, default 16: width of exception event counter.
REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  in  1  core clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ws_valid, ws_pc  in  1, 32  writeback instruction valid and its PC.
REQ-007 ws_ex, ws_ecode, ws_esubcode, ws_badv  in  1, 6, 9, 32  synchronous exception flag, code, subcode and faulting address.
REQ-008 ws_ertn  in  1  writeback instruction is ertn.
REQ-009 csr_estat_is, csr_ecfg_lie, csr_crmd_ie  in  13, 13, 1  interrupt status, enable mask and global enable from the CSR file.
REQ-010 csr_eentry, csr_era  in  32, 32  exception entry and return address from the CSR file.
REQ-011 ws_allowin  out  1  writeback may present a new instruction.
REQ-012 wb_ex, wb_ertn_flush  out  1, 1  one-cycle commit pulses to the CSR file.
REQ-013 wb_ecode, wb_esubcode, wb_pc, wb_ex_ale_addr  out  6, 9, 32, 32  exception info to the CSR file.
REQ-014 pipe_flush  out  1  flush all younger pipeline stages.
REQ-015 redir_valid, redir_pc  out  1, 32  redirect request to fetch; redir_ready  in  1  fetch accepts.
REQ-016 int_pending  out  1  registered interrupt request; ex_cnt  out  CNT_W  committed exception count.

Function
REQ-017 int_pending SHALL be registered each cycle as csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie).
REQ-018 FSM states SHALL be IDLE, COMMIT, REDIRECT; ws_allowin = (state==IDLE).
REQ-019 In IDLE with ws_valid, the event SHALL be selected by priority interrupt (int_pending) > ws_ex > ws_ertn; no event -> normal retire, stay IDLE.
REQ-020 Interrupts SHALL attach only to a valid writeback instruction; with ws_valid=0 the FSM waits in IDLE.
REQ-021 On event, ecode/esubcode/pc/badv SHALL be captured (interrupt: ECODE_INT, esubcode 0, badv 0) and the FSM SHALL move to COMMIT.
REQ-022 In COMMIT (exactly 1 cycle) wb_ex=1 for interrupt/exception or wb_ertn_flush=1 for ertn, never both; wb_* outputs hold captured values; then REDIRECT.
REQ-023 In REDIRECT redir_valid=1; redir_pc = csr_eentry for exceptions/interrupts, csr_era for ertn, sampled in REDIRECT (after CSR update); redir_pc stable while redir_valid && !redir_ready.
REQ-024 redir_valid && redir_ready SHALL return FSM to IDLE next cycle; latency event->redirect accept >= 2 cycles.
REQ-025 pipe_flush SHALL be 1 in COMMIT and REDIRECT, 0 in IDLE.
REQ-026 ws_* inputs SHALL be ignored outside IDLE.
REQ-027 ex_cnt SHALL increment by 1 per wb_ex pulse (not ertn) and saturate at all-ones.
REQ-028 wb_* data outputs SHALL be 0 when not in COMMIT.

Reset
REQ-029 rst SHALL force IDLE, int_pending=0, ex_cnt=0, all outputs 0 except ws_allowin=1, overriding any in-flight COMMIT/REDIRECT.
REQ-030 First cycle after rst deasserts, the block SHALL accept a ws_valid event normally.

Structure
REQ-031 Shared package SHALL hold ecode constants (INT 0x0, ADE 0x8, ALE 0x9, SYS 0xB) and the FSM state encoding.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 ws_valid, ws_ex, ecode 0x9, badv 0x1C000003, pc 0x1C000010, redir_ready=1 -> next cycle wb_ex=1, wb_ecode=0x9, wb_ex_ale_addr=0x1C000003, wb_pc=0x1C000010; then redir_valid=1, redir_pc=csr_eentry; ex_cnt=1.
REQ-034 ws_ertn, csr_era=0x1C000100 -> wb_ertn_flush pulse, wb_ex=0, redir_pc=0x1C000100, ex_cnt unchanged.
REQ-035 crmd_ie=1, lie bit11=1, is bit11=1, plus ws_ex ecode 0x8 same cycle -> wb_ecode=0x0, one wb_ex pulse only.
REQ-036 redir_ready held 0 for 5 cycles -> redir_valid and redir_pc stable, pipe_flush=1, ws_allowin=0, new ws_valid ignored.
REQ-037 rst asserted during REDIRECT -> next cycle IDLE, redir_valid=0, pipe_flush=0, ex_cnt=0.
REQ-038 CNT_W=2, four exceptions -> ex_cnt 1,2,3,3.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl_pkg
// Shared definitions for the exception/ertn commit controller:
//   - architectural exception codes used by the commit logic
//   - FSM state encoding
//   - the record captured when an event is accepted in writeback
// -----------------------------------------------------------------------------
package exc_commit_ctrl_pkg;

    // Exception codes (ESTAT.Ecode values)
    localparam logic [5:0] EC_INT = 6'h0;   // interrupt
    localparam logic [5:0] EC_ADE = 6'h8;   // address error
    localparam logic [5:0] EC_ALE = 6'h9;   // address alignment error
    localparam logic [5:0] EC_SYS = 6'hB;   // syscall

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Everything the CSR file and the redirect need about the accepted event.
    typedef struct packed {
        logic        is_ertn;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
        logic [31:0] badv;
    } exc_info_t;

endpackage

// File: rtl/exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl
// Commits interrupts, synchronous exceptions and ertn at the writeback stage.
// An accepted event spends one cycle in COMMIT (pulse to the CSR file), then
// waits in REDIRECT until fetch accepts the new PC.
//
// Parameters
//   ECODE_INT  ecode reported for interrupts
//   CNT_W      width of the committed-exception counter
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ws_valid, ws_pc              writeback instruction valid / PC
//   ws_ex, ws_ecode, ws_esubcode, ws_badv   synchronous exception info
//   ws_ertn                      writeback instruction is ertn
//   csr_estat_is, csr_ecfg_lie, csr_crmd_ie interrupt status/mask/enable
//   csr_eentry, csr_era          exception entry / return address
//   ws_allowin                   writeback may present a new instruction
//   wb_ex, wb_ertn_flush         one-cycle commit pulses to the CSR file
//   wb_ecode, wb_esubcode, wb_pc, wb_ex_ale_addr  captured event info
//   pipe_flush                   flush all younger stages
//   redir_valid, redir_pc, redir_ready  redirect handshake with fetch
//   int_pending                  registered interrupt request
//   ex_cnt                       saturating count of committed exceptions
// -----------------------------------------------------------------------------
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [5:0]  ECODE_INT = EC_INT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ws_valid,
    input  logic [31:0]      ws_pc,
    input  logic             ws_ex,
    input  logic [5:0]       ws_ecode,
    input  logic [8:0]       ws_esubcode,
    input  logic [31:0]      ws_badv,
    input  logic             ws_ertn,

    input  logic [12:0]      csr_estat_is,
    input  logic [12:0]      csr_ecfg_lie,
    input  logic             csr_crmd_ie,
    input  logic [31:0]      csr_eentry,
    input  logic [31:0]      csr_era,

    output logic             ws_allowin,
    output logic             wb_ex,
    output logic             wb_ertn_flush,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_ex_ale_addr,
    output logic             pipe_flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             int_pending,
    output logic [CNT_W-1:0] ex_cnt
);

    state_e      state, state_nxt;
    exc_info_t   cap_q, cap_nxt;
    logic        redir_first_q;   // first cycle of REDIRECT: CSR values are fresh
    logic [31:0] redir_pc_q;      // redirect target held while fetch stalls
    logic [31:0] redir_target;
    logic        in_commit;
    logic        in_redirect;

    assign in_commit   = (state == ST_COMMIT);
    assign in_redirect = (state == ST_REDIRECT);

    // -------------------------------------------------------------------------
    // Next state and event capture
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        cap_nxt   = cap_q;
        case (state)
            ST_IDLE: begin
                // Interrupts only ride on a real instruction; priority is
                // interrupt > exception > ertn.
                if (ws_valid && (int_pending || ws_ex || ws_ertn)) begin
                    state_nxt = ST_COMMIT;
                    if (int_pending) begin
                        cap_nxt = '{is_ertn: 1'b0, ecode: ECODE_INT, esubcode: 9'h0,
                                    pc: ws_pc, badv: 32'h0};
                    end else if (ws_ex) begin
                        cap_nxt = '{is_ertn: 1'b0, ecode: ws_ecode, esubcode: ws_esubcode,
                                    pc: ws_pc, badv: ws_badv};
                    end else begin
                        cap_nxt = '{is_ertn: 1'b1, ecode: 6'h0, esubcode: 9'h0,
                                    pc: ws_pc, badv: 32'h0};
                    end
                end
            end
            ST_COMMIT:   state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redir_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= ST_IDLE;
            cap_q         <= '0;
            redir_first_q <= 1'b0;
            redir_pc_q    <= 32'h0;
            int_pending   <= 1'b0;
            ex_cnt        <= '0;
        end else begin
            state         <= state_nxt;
            cap_q         <= cap_nxt;
            redir_first_q <= in_commit;
            if (in_redirect) redir_pc_q <= redir_pc;
            int_pending   <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
            if (wb_ex && (ex_cnt != {CNT_W{1'b1}})) ex_cnt <= ex_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ws_allowin     = (state == ST_IDLE);
    assign wb_ex          = in_commit & ~cap_q.is_ertn;
    assign wb_ertn_flush  = in_commit &  cap_q.is_ertn;
    assign wb_ecode       = in_commit ? cap_q.ecode    : 6'h0;
    assign wb_esubcode    = in_commit ? cap_q.esubcode : 9'h0;
    assign wb_pc          = in_commit ? cap_q.pc       : 32'h0;
    assign wb_ex_ale_addr = in_commit ? cap_q.badv     : 32'h0;
    assign pipe_flush     = in_commit | in_redirect;
    assign redir_valid    = in_redirect;

    // The CSR file updates at the end of COMMIT, so eentry/era are only
    // meaningful from the first REDIRECT cycle; after that the target is
    // frozen so it cannot move under a stalled handshake.
    assign redir_target = cap_q.is_ertn ? csr_era : csr_eentry;
    assign redir_pc     = !in_redirect  ? 32'h0
                        : redir_first_q ? redir_target
                        :                 redir_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_commit_ctrl
// Randomised + directed stimulus, scoreboard of expected commits, and a
// negedge monitor comparing DUT outputs with a behavioural model. A second
// instance with CNT_W=2 follows the same stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_exc_commit_ctrl;

    localparam logic [5:0] TB_ECODE_INT = 6'h0;
    localparam int         CNT_MAX      = 65535;
    localparam int         CNT2_MAX     = 3;

    typedef struct {
        bit          is_ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc;
        logic [31:0] badv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ws_valid = 1'b0, ws_ex = 1'b0, ws_ertn = 1'b0;
    logic [31:0] ws_pc = '0, ws_badv = '0;
    logic [5:0]  ws_ecode = '0;
    logic [8:0]  ws_esubcode = '0;
    logic [12:0] csr_estat_is = '0, csr_ecfg_lie = '0;
    logic        csr_crmd_ie = 1'b0;
    logic [31:0] csr_eentry = '0, csr_era = '0;
    logic        redir_ready = 1'b0;

    logic        ws_allowin, wb_ex, wb_ertn_flush, pipe_flush, redir_valid, int_pending;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_ex_ale_addr, redir_pc;
    logic [15:0] ex_cnt;

    logic        ws_allowin_2, wb_ex_2, wb_ertn_flush_2, pipe_flush_2, redir_valid_2, int_pending_2;
    logic [5:0]  wb_ecode_2;
    logic [8:0]  wb_esubcode_2;
    logic [31:0] wb_pc_2, wb_ex_ale_addr_2, redir_pc_2;
    logic [1:0]  ex_cnt_2;

    always #5 clk = ~clk;

    exc_commit_ctrl u_dut (
        .clk(clk), .rst(rst),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_ex(ws_ex), .ws_ecode(ws_ecode),
        .ws_esubcode(ws_esubcode), .ws_badv(ws_badv), .ws_ertn(ws_ertn),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ws_allowin(ws_allowin), .wb_ex(wb_ex), .wb_ertn_flush(wb_ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_ex_ale_addr(wb_ex_ale_addr), .pipe_flush(pipe_flush),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .int_pending(int_pending), .ex_cnt(ex_cnt)
    );

    exc_commit_ctrl #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_ex(ws_ex), .ws_ecode(ws_ecode),
        .ws_esubcode(ws_esubcode), .ws_badv(ws_badv), .ws_ertn(ws_ertn),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ws_allowin(ws_allowin_2), .wb_ex(wb_ex_2), .wb_ertn_flush(wb_ertn_flush_2),
        .wb_ecode(wb_ecode_2), .wb_esubcode(wb_esubcode_2), .wb_pc(wb_pc_2),
        .wb_ex_ale_addr(wb_ex_ale_addr_2), .pipe_flush(pipe_flush_2),
        .redir_valid(redir_valid_2), .redir_pc(redir_pc_2), .redir_ready(redir_ready),
        .int_pending(int_pending_2), .ex_cnt(ex_cnt_2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard monitor (negedge)
    // -------------------------------------------------------------------------
    exp_t        exp_q[$];
    int          model_cnt = 0;
    int          model_cnt2 = 0;
    bit          redir_active = 0, redir_first = 0, cur_ertn = 0;
    logic [31:0] exp_redir = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            model_cnt    = 0;
            model_cnt2   = 0;
            redir_active = 0;
            redir_first  = 0;
        end else begin
            if (redir_first && !redir_valid) begin
                check("redir_missing", redir_valid, 1);
                redir_first  = 0;
                redir_active = 0;
            end
            if (wb_ex || wb_ertn_flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", {wb_ex, wb_ertn_flush}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_kind", {wb_ex, wb_ertn_flush, wb_ex_2, wb_ertn_flush_2},
                          e.is_ertn ? 4'b0101 : 4'b1010);
                    check("wb_pc", wb_pc, e.pc);
                    if (!e.is_ertn) begin
                        check("wb_ecode", wb_ecode, e.ecode);
                        check("wb_esubcode", wb_esubcode, e.esub);
                        check("wb_badv", wb_ex_ale_addr, e.badv);
                        if (model_cnt < CNT_MAX) model_cnt++;
                        if (model_cnt2 < CNT2_MAX) model_cnt2++;
                    end
                    check("commit_flush", {pipe_flush, ws_allowin, redir_valid}, 3'b100);
                    redir_active = 1;
                    redir_first  = 1;
                    cur_ertn     = e.is_ertn;
                end
            end else begin
                check("wb_idle_zero",
                      (wb_ecode == 0 && wb_esubcode == 0 && wb_pc == 0 && wb_ex_ale_addr == 0), 1);
            end
            if (redir_valid) begin
                if (!redir_active) begin
                    check("unexpected_redir", redir_valid, 0);
                end else begin
                    if (redir_first) begin
                        exp_redir   = cur_ertn ? csr_era : csr_eentry;
                        redir_first = 0;
                        check("ex_cnt", ex_cnt, model_cnt);
                        check("ex_cnt_w2", ex_cnt_2, model_cnt2);
                    end
                    check("redir_pc", redir_pc, exp_redir);
                    check("redir_flush", {pipe_flush, ws_allowin, pipe_flush_2}, 3'b101);
                    if (redir_ready) redir_active = 0;
                end
            end
            if (ws_allowin) begin
                check("idle_outputs", {pipe_flush, redir_valid, wb_ex, wb_ertn_flush,
                                       redir_valid_2, (redir_pc != 0)}, 0);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus (drives at posedge + 1)
    // -------------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        while (!ws_allowin && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ws_allowin) check("idle_timeout", ws_allowin, 1);
    endtask

    // Runs from the COMMIT cycle until the FSM is back in IDLE, feeding junk
    // into writeback meanwhile. rmode: 0 random ready, 1 always ready,
    // 2 ready withheld for the first five REDIRECT cycles.
    task automatic drain(input int rmode, input bit scramble);
        int k = 0;
        while (!ws_allowin && k < 100) begin
            if (rmode == 2 && k >= 1 && k <= 5)
                check("stall_hold", {redir_valid, pipe_flush, ws_allowin}, 3'b110);
            ws_valid = 1'($urandom);
            ws_ex    = 1'($urandom);
            ws_ertn  = 1'($urandom);
            ws_pc    = $urandom;
            ws_ecode = 6'($urandom);
            if (scramble || (rmode == 2 && k >= 2)) begin
                csr_eentry = $urandom;
                csr_era    = $urandom;
            end
            case (rmode)
                0:       redir_ready = 1'($urandom);
                1:       redir_ready = 1'b1;
                default: redir_ready = (k >= 6);
            endcase
            @(posedge clk); #1;
            k++;
        end
        if (!ws_allowin) check("txn_timeout", ws_allowin, 1);
        ws_valid = 1'b0;
    endtask

    task automatic issue(input logic ie, input logic [12:0] is_v, input logic [12:0] lie_v,
                         input logic ex, input logic ertn, input logic [5:0] ec,
                         input logic [8:0] sc, input logic [31:0] pc, input logic [31:0] bv,
                         input int rmode, input logic [31:0] eentry_v, input logic [31:0] era_v,
                         input bit scramble);
        exp_t e;
        bit   intr;
        wait_idle();
        csr_crmd_ie  = ie;
        csr_estat_is = is_v;
        csr_ecfg_lie = lie_v;
        ws_valid     = 1'b0;
        @(posedge clk); #1;
        intr = ie && ((is_v & lie_v) != 13'h0);
        check("int_pending", int_pending, intr);
        ws_valid = 1'b1; ws_ex = ex; ws_ertn = ertn; ws_ecode = ec;
        ws_esubcode = sc; ws_pc = pc; ws_badv = bv;
        csr_eentry = eentry_v; csr_era = era_v;
        if (intr || ex || ertn) begin
            e.is_ertn = !intr && !ex;
            e.ecode   = intr ? TB_ECODE_INT : ec;
            e.esub    = intr ? 9'h0 : sc;
            e.pc      = pc;
            e.badv    = intr ? 32'h0 : bv;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (!(intr || ex || ertn)) begin
            check("retire_allowin", ws_allowin, 1);
            ws_valid = 1'b0;
        end else begin
            drain(rmode, scramble);
        end
    endtask

    initial begin
        exp_t e;
        int   r;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ws_allowin, wb_ex, wb_ertn_flush, pipe_flush, redir_valid,
                              int_pending, (ex_cnt != 0), (redir_pc != 0)}, 8'b1000_0000);
        rst = 1'b0;

        // ALE exception with known values, fetch always ready
        issue(0, 13'h0, 13'h0, 1, 0, 6'h9, 9'h0, 32'h1C000010, 32'h1C000003,
              1, 32'h1C008000, 32'h0, 0);
        // ertn returns to csr_era, counter unchanged
        issue(0, 13'h0, 13'h0, 0, 1, 6'h0, 9'h0, 32'h1C000050, 32'h0,
              1, 32'h1C008000, 32'h1C000100, 0);
        // Interrupt beats a same-cycle ADE exception
        issue(1, 13'h800, 13'h800, 1, 0, 6'h8, 9'h1, 32'h1C000060, 32'hDEAD0000,
              1, 32'h1C008000, 32'h0, 0);
        // Masked interrupt (ie=0) and no other event: plain retire
        issue(0, 13'h800, 13'h800, 0, 0, 6'h0, 9'h0, 32'h1C000070, 32'h0,
              1, 32'h0, 32'h0, 0);
        // Fetch stalls redirect for five cycles while CSRs and writeback churn
        issue(0, 13'h0, 13'h0, 1, 0, 6'hB, 9'h0, 32'h1C000080, 32'h0,
              2, 32'h1C00A000, 32'h1C00B000, 0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            issue($urandom_range(0, 3) == 0, 13'($urandom), 13'($urandom),
                  r < 40, (r >= 30 && r < 65), 6'($urandom), 9'($urandom),
                  $urandom, $urandom, 0, $urandom, $urandom, 1);
        end

        // Reset in the middle of REDIRECT
        wait_idle();
        csr_crmd_ie = 1'b0;
        ws_valid    = 1'b0;
        @(posedge clk); #1;
        ws_valid = 1'b1; ws_ex = 1'b1; ws_ertn = 1'b0; ws_ecode = 6'hB;
        ws_esubcode = 9'h0; ws_pc = 32'h1C000200; ws_badv = 32'h0; redir_ready = 1'b0;
        e = '{is_ertn: 0, ecode: 6'hB, esub: 9'h0, pc: 32'h1C000200, badv: 32'h0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        ws_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_redir", redir_valid, 1);
        rst = 1'b1;
        csr_crmd_ie = 1'b1; csr_estat_is = 13'h1; csr_ecfg_lie = 13'h1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_reset_state", {ws_allowin, redir_valid, pipe_flush, wb_ex, wb_ertn_flush,
                                   int_pending, (ex_cnt != 0), (ex_cnt_2 != 0)}, 8'b1000_0000);
        // First cycle out of reset: int_pending is still 0, so the exception wins
        ws_valid = 1'b1; ws_ex = 1'b1; ws_ertn = 1'b0; ws_ecode = 6'h9;
        ws_esubcode = 9'h0; ws_pc = 32'h1C000300; ws_badv = 32'h1C000301;
        csr_eentry = 32'h1C00C000;
        e = '{is_ertn: 0, ecode: 6'h9, esub: 9'h0, pc: 32'h1C000300, badv: 32'h1C000301};
        exp_q.push_back(e);
        @(posedge clk); #1;
        drain(1, 0);

        // Three more exceptions: 2-bit counter goes 2,3,3
        for (int i = 0; i < 3; i++)
            issue(0, 13'h0, 13'h0, 1, 0, 6'h8, 9'h0, 32'h1C000400 + 32'(i * 4), 32'h0,
                  1, 32'h1C00D000, 32'h0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
